// File: rtl/inst_fetch_queue.sv
// IF->ID instruction FIFO of {PC, instr}; show-ahead head, entries visible 1 cycle after push.
// Backpressure: ReadyF drops when full (push dropped); empty head reads as a zero NOP bubble.
module inst_fetch_queue #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 32,
  parameter int DEPTH  = 4,
  parameter int CNT_W  = $clog2(DEPTH) + 1
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              FlushQ,
  input  logic              PushF,
  input  logic [DATA_W-1:0] InstrF,
  input  logic [ADDR_W-1:0] PCF,
  output logic              ReadyF,
  input  logic              PopD,
  output logic              ValidD,
  output logic [DATA_W-1:0] InstrD,
  output logic [ADDR_W-1:0] PCD,
  output logic [ADDR_W-1:0] PCPlus4D,
  output logic [CNT_W-1:0]  Count,
  output logic              AlmostFull
);

  localparam int               PTR_W     = $clog2(DEPTH);
  localparam logic [CNT_W-1:0] FULL_CNT  = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0] AFULL_CNT = CNT_W'(DEPTH - 1);

  logic [DATA_W-1:0] r_instr [DEPTH];
  logic [ADDR_W-1:0] r_pc    [DEPTH];
  logic [PTR_W-1:0]  r_wr_ptr;
  logic [PTR_W-1:0]  r_rd_ptr;
  logic [CNT_W-1:0]  r_count;

  logic              w_push_ok;
  logic              w_pop_ok;
  logic [DATA_W-1:0] w_head_instr;
  logic [ADDR_W-1:0] w_head_pc;

  assign ValidD     = (r_count != '0);
  assign ReadyF     = (r_count != FULL_CNT);
  assign Count      = r_count;
  assign AlmostFull = (r_count >= AFULL_CNT);

  // A flush in the same cycle wins over any push or pop request.
  assign w_push_ok = PushF & ReadyF & ~FlushQ;
  assign w_pop_ok  = PopD  & ValidD & ~FlushQ;

  assign w_head_instr = r_instr[r_rd_ptr];
  assign w_head_pc    = r_pc[r_rd_ptr];

  // Gate the head so an empty queue presents exact zeros rather than stale data.
  assign InstrD   = ValidD ? w_head_instr : '0;
  assign PCD      = ValidD ? w_head_pc : '0;
  assign PCPlus4D = ValidD ? (w_head_pc + ADDR_W'(4)) : '0;

  always_ff @(posedge CLK) begin
    if (w_push_ok && !RST) begin
      r_instr[r_wr_ptr] <= InstrF;
      r_pc[r_wr_ptr]    <= PCF;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST || FlushQ) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push_ok) begin
        r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      end
      if (w_pop_ok) begin
        r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      end
      case ({w_push_ok, w_pop_ok})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: tb/tb_inst_fetch_queue.sv
// Directed + random bench for inst_fetch_queue (DEPTH=4) against a queue-based reference model.
module tb_inst_fetch_queue;

  localparam int DATA_W = 32;
  localparam int ADDR_W = 32;
  localparam int DEPTH  = 4;
  localparam int CNT_W  = $clog2(DEPTH) + 1;

  logic              CLK = 1'b0;
  logic              RST = 1'b1;
  logic              FlushQ = 1'b0;
  logic              PushF = 1'b0;
  logic [DATA_W-1:0] InstrF = '0;
  logic [ADDR_W-1:0] PCF = '0;
  logic              ReadyF;
  logic              PopD = 1'b0;
  logic              ValidD;
  logic [DATA_W-1:0] InstrD;
  logic [ADDR_W-1:0] PCD;
  logic [ADDR_W-1:0] PCPlus4D;
  logic [CNT_W-1:0]  Count;
  logic              AlmostFull;

  inst_fetch_queue #(
    .DATA_W(DATA_W), .ADDR_W(ADDR_W), .DEPTH(DEPTH), .CNT_W(CNT_W)
  ) dut (
    .CLK(CLK), .RST(RST), .FlushQ(FlushQ), .PushF(PushF), .InstrF(InstrF), .PCF(PCF),
    .ReadyF(ReadyF), .PopD(PopD), .ValidD(ValidD), .InstrD(InstrD), .PCD(PCD),
    .PCPlus4D(PCPlus4D), .Count(Count), .AlmostFull(AlmostFull)
  );

  always #5 CLK = ~CLK;

  typedef struct packed {
    logic [ADDR_W-1:0] pc;
    logic [DATA_W-1:0] instr;
  } ent_t;

  ent_t q[$];
  int   n_vec = 0;
  int   n_err = 0;
  bit   chk_en = 1'b0;

  function automatic logic [DATA_W-1:0] instr_of(input logic [ADDR_W-1:0] pc);
    return 32'h2400_0000 ^ {pc[15:0], ~pc[15:0]};
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: plain FIFO queue updated from the inputs seen at each edge.
  always @(posedge CLK) begin
    bit push_ok, pop_ok;
    if (RST || FlushQ) begin
      q.delete();
    end else begin
      push_ok = PushF && (q.size() < DEPTH);
      pop_ok  = PopD && (q.size() > 0);
      if (pop_ok) void'(q.pop_front());
      if (push_ok) q.push_back('{pc: PCF, instr: InstrF});
    end
  end

  always @(negedge CLK) begin
    if (chk_en) begin
      bit vld;
      vld = (q.size() != 0);
      chk("ValidD", 64'(ValidD), 64'(vld));
      chk("ReadyF", 64'(ReadyF), 64'(q.size() != DEPTH));
      chk("Count", 64'(Count), 64'(q.size()));
      chk("AlmostFull", 64'(AlmostFull), 64'(q.size() >= DEPTH - 1));
      chk("InstrD", 64'(InstrD), vld ? 64'(q[0].instr) : 64'd0);
      chk("PCD", 64'(PCD), vld ? 64'(q[0].pc) : 64'd0);
      chk("PCPlus4D", 64'(PCPlus4D), vld ? 64'(q[0].pc + 32'd4) : 64'd0);
    end
  end

  // Apply inputs for one cycle; returns 1 time unit after the edge that sampled them.
  task automatic cyc(input bit push, input bit pop, input bit flush, input logic [ADDR_W-1:0] pc);
    PushF  = push;
    PopD   = pop;
    FlushQ = flush;
    PCF    = pc;
    InstrF = instr_of(pc);
    @(posedge CLK);
    #1;
  endtask

  initial begin
    // Reset held 2 cycles with a push pending: nothing may be stored.
    RST = 1'b1;
    cyc(1, 0, 0, 32'h100);
    chk_en = 1'b1;
    cyc(1, 0, 0, 32'h104);
    RST = 1'b0;
    cyc(0, 0, 0, 32'h0);
    chk("rst_ValidD", 64'(ValidD), 64'd0);
    chk("rst_ReadyF", 64'(ReadyF), 64'd1);
    chk("rst_Count", 64'(Count), 64'd0);
    chk("rst_InstrD", 64'(InstrD), 64'd0);
    chk("rst_PCPlus4D", 64'(PCPlus4D), 64'd0);
    chk("rst_AlmostFull", 64'(AlmostFull), 64'd0);

    // Fill to DEPTH, fifth push is dropped.
    for (int i = 0; i < 4; i++) cyc(1, 0, 0, 32'(i * 4));
    chk("fill_Count", 64'(Count), 64'd4);
    chk("fill_ReadyF", 64'(ReadyF), 64'd0);
    chk("fill_AlmostFull", 64'(AlmostFull), 64'd1);
    cyc(1, 0, 0, 32'h10);
    chk("drop_Count", 64'(Count), 64'd4);

    // Drain in order.
    for (int i = 0; i < 4; i++) begin
      chk("drain_PCD", 64'(PCD), 64'(i * 4));
      chk("drain_PCPlus4D", 64'(PCPlus4D), 64'(i * 4 + 4));
      cyc(0, 1, 0, 32'h0);
    end
    chk("drained_ValidD", 64'(ValidD), 64'd0);
    chk("drained_PCD", 64'(PCD), 64'd0);

    // Steady push+pop at Count=2 across several pointer wraps.
    cyc(1, 0, 0, 32'h20);
    cyc(1, 0, 0, 32'h24);
    for (int i = 0; i < 10; i++) begin
      chk("pp_PCD", 64'(PCD), 64'(32'h20 + i * 4));
      cyc(1, 1, 0, 32'(32'h28 + i * 4));
      chk("pp_Count", 64'(Count), 64'd2);
    end
    chk("pp_head", 64'(PCD), 64'h48);
    cyc(0, 1, 0, 32'h0);
    cyc(0, 1, 0, 32'h0);

    // Full: same-cycle push is rejected, pop proceeds.
    for (int i = 0; i < 4; i++) cyc(1, 0, 0, 32'(32'h80 + i * 4));
    cyc(1, 1, 0, 32'h90);
    chk("fullpp_Count", 64'(Count), 64'd3);
    chk("fullpp_PCD", 64'(PCD), 64'h84);
    for (int i = 0; i < 3; i++) begin
      chk("fullpp_drain", 64'(PCD), 64'(32'h84 + i * 4));
      cyc(0, 1, 0, 32'h0);
    end

    // Empty: pop ignored, push stored, no fall-through.
    chk("empty_ValidD", 64'(ValidD), 64'd0);
    cyc(1, 1, 0, 32'hA0);
    chk("emptypp_Count", 64'(Count), 64'd1);
    chk("emptypp_PCD", 64'(PCD), 64'hA0);
    cyc(0, 1, 0, 32'h0);

    // Flush at Count=3 with push and pop both requested.
    for (int i = 0; i < 3; i++) cyc(1, 0, 0, 32'(32'hB0 + i * 4));
    cyc(1, 1, 1, 32'hBC);
    chk("flush_Count", 64'(Count), 64'd0);
    chk("flush_ValidD", 64'(ValidD), 64'd0);
    chk("flush_InstrD", 64'(InstrD), 64'd0);
    cyc(1, 0, 0, 32'h40);
    chk("postflush_PCD", 64'(PCD), 64'h40);
    chk("postflush_InstrD", 64'(InstrD), 64'(instr_of(32'h40)));

    // Reset mid-stream overrides traffic.
    cyc(1, 0, 0, 32'h44);
    RST = 1'b1;
    cyc(1, 1, 0, 32'h48);
    RST = 1'b0;
    chk("midrst_Count", 64'(Count), 64'd0);

    // Random traffic checked cycle-by-cycle against the model.
    for (int i = 0; i < 3000; i++) begin
      cyc($urandom_range(0, 9) < 7, $urandom_range(0, 9) < 6, $urandom_range(0, 99) < 3,
          32'(i * 4 + 32'h1000));
    end
    cyc(0, 0, 0, 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/inst_fetch_queue.md
Name: inst_fetch_queue

Overview:
- Parametrised instruction fetch buffer between the IF and ID stages of the pipelined MIPS32 core.
- Replaces the single-entry IF/ID register with a DEPTH-entry FIFO of {PC, instruction} pairs, so fetch can run ahead while ID is stalled.
- Provides a valid/ready handshake on both sides, and a flush for taken branches and jumps.
- When empty, it presents a NOP bubble to ID.

Parameters:
- DATA_W, 32: instruction width in bits.
- ADDR_W, 32: PC width in bits.
- DEPTH, 4: number of entries. Must be a power of 2 and at least 2.
- CNT_W, $clog2(DEPTH)+1: width of the occupancy counter.

Ports:
- CLK  input  1  clock; all state updates on the rising edge.
- RST  input  1  synchronous active-high reset.
- FlushQ  input  1  discard all entries; driven when a branch or jump redirects the PC in ID.
- PushF  input  1  IF presents a valid instruction.
- InstrF  input  DATA_W  instruction from InstructionRAM.
- PCF  input  ADDR_W  PC of InstrF.
- ReadyF  output  1  queue can accept a push this cycle.
- PopD  input  1  ID consumes the head entry this cycle.
- ValidD  output  1  head entry valid.
- InstrD  output  DATA_W  head instruction; 0 (NOP) when ValidD=0.
- PCD  output  ADDR_W  head PC; 0 when ValidD=0.
- PCPlus4D  output  ADDR_W  PCD+4 when ValidD=1, else 0.
- Count  output  CNT_W  current occupancy, 0..DEPTH.
- AlmostFull  output  1  Count >= DEPTH-1.

Behaviour:
- Reset: RST=1 at a clock edge clears wr_ptr, rd_ptr and Count to 0. Storage contents are don't-care.
- Reset outputs: ValidD=0, ReadyF=1, InstrD=0, PCD=0, PCPlus4D=0, Count=0, AlmostFull=0 (for DEPTH>=2 with Count=0, this holds only if DEPTH-1>0).
- Reset has priority over every other input, including mid-stream traffic.
- Combinational status outputs:
  - ValidD = (Count != 0).
  - ReadyF = (Count != DEPTH).
- Head outputs are show-ahead: InstrD, PCD and PCPlus4D read the entry at rd_ptr combinationally, gated to 0 when ValidD=0.
- Push accept: push_ok = PushF & ReadyF & ~FlushQ. On accept, write {PCF, InstrF} to the entry at wr_ptr, and wr_ptr advances by 1 modulo DEPTH (natural wrap).
- Pop accept: pop_ok = PopD & ValidD & ~FlushQ. On accept, rd_ptr advances by 1 modulo DEPTH.
- Ignored requests: PopD while empty is ignored. PushF while full is ignored and the data is dropped; IF must hold its PC while ReadyF=0.
- Count update:
  - +1 on push_ok only.
  - -1 on pop_ok only.
  - Unchanged when both accept, or when neither does.
- Simultaneous push and pop:
  - Partially filled: both take effect and Count is unchanged.
  - Full: the push is rejected (ReadyF=0); the pop proceeds and Count becomes DEPTH-1.
  - Empty: the pop is ignored and the push is stored; there is no fall-through.
- Latency: a pushed entry appears on ValidD/InstrD on the cycle after the accepting edge, minimum 1 cycle.
- Flush: FlushQ=1 at an edge (and RST=0) sets wr_ptr=rd_ptr=0 and Count=0. Any same-cycle PushF or PopD is discarded. ValidD=0 on the next cycle.
- Ordering: strict FIFO. The output PC sequence equals the accepted push sequence.
- Wrap: pointers are log2(DEPTH) bits and wrap naturally. Full versus empty is resolved by Count, not by pointer equality.
- No X propagation: when ValidD=0, InstrD, PCD and PCPlus4D are exactly 0.

Test Plan:
- Reset: hold RST for 2 cycles with PushF=1 -> ValidD=0, ReadyF=1, Count=0, InstrD=0 after release; nothing was stored.
- Fill/drain, DEPTH=4: push PCs 0x00, 0x04, 0x08, 0x0C with PopD=0 -> Count=4, ReadyF=0, AlmostFull=1.
  - A fifth push (PC 0x10) is dropped.
  - Then PopD=1 for 4 cycles -> PCD sequence 0x00, 0x04, 0x08, 0x0C; PCPlus4D = 0x04..0x10; then ValidD=0.
- Simultaneous push/pop at Count=2 -> Count stays 2 across 10 cycles, with order preserved through ≥2 pointer wraps.
- Full plus pop plus push in the same cycle -> push rejected, Count 4->3.
- Empty plus push plus pop in the same cycle -> Count 0->1, entry readable on the next cycle.
- Flush with Count=3 while PushF=1 and PopD=1 -> next cycle Count=0, ValidD=0, InstrD=0.
  - A subsequent push of PC 0x40 appears at the head, not any stale entry.
- Parameter sweep: DEPTH=2 and DEPTH=16, DATA_W=32, with random push/pop/flush for 10k cycles against a scoreboard.
  - No loss, duplication or reordering.
  - Count is never above DEPTH.
  - Count never underflows.
